// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: one holding slot per functional unit, one register-file write per cycle.
// Optional macro WB_BYPASS_EN lets an empty slot's incoming result win arbitration in the same cycle.
module wb_arbiter #(
    parameter int N_FU = 5,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_FU-1:0]      req_valid,
    input  logic [5*N_FU-1:0]    req_rd,
    input  logic [XLEN*N_FU-1:0] req_data,
    output logic [N_FU-1:0]      req_ready,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [2:0]           wb_fu,
    output logic [2:0]           pending_cnt
);

    localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]  r_full;
    logic [4:0]       r_rd_q   [N_FU];
    logic [XLEN-1:0]  r_data_q [N_FU];
    logic [PTR_W-1:0] r_rr_ptr;
    logic [2:0]       r_pending;

    logic [N_FU-1:0]  w_req_nz;
    logic [N_FU-1:0]  w_cand;
    logic [N_FU-1:0]  w_grant;
    logic [PTR_W-1:0] w_gidx;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;
    logic [N_FU-1:0]  w_acc;
    logic [N_FU-1:0]  w_load;
    logic [N_FU-1:0]  w_full_nxt;

    function automatic int rr_index(input int base, input int k);
        int s;
        s = base + k;
        return (s >= N_FU) ? s - N_FU : s;
    endfunction

    function automatic logic [2:0] popcount(input logic [N_FU-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < N_FU; i++) c = c + 3'(v[i]);
        return c;
    endfunction

    always_comb begin
        w_req_nz = '0;
        for (int i = 0; i < N_FU; i++) w_req_nz[i] = |req_rd[5*i +: 5];
    end

    // An incoming non-zero-rd request into an empty slot competes like a full slot.
`ifdef WB_BYPASS_EN
    assign w_cand = r_full | (req_valid & w_req_nz);
`else
    assign w_cand = r_full;
`endif

    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_FU; k++) begin
            w_idx = PTR_W'(rr_index(int'(r_rr_ptr), k));
            if (!w_found && w_cand[w_idx]) begin
                w_found         = 1'b1;
                w_gidx          = w_idx;
                w_grant[w_idx]  = 1'b1;
            end
        end
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        wb_fu   = '0;
        if (w_found) begin
            wb_en   = 1'b1;
            wb_fu   = 3'(w_gidx);
            wb_rd   = r_rd_q[w_gidx];
            wb_data = r_data_q[w_gidx];
`ifdef WB_BYPASS_EN
            if (!r_full[w_gidx]) begin
                wb_rd   = req_rd[5*w_gidx +: 5];
                wb_data = req_data[XLEN*w_gidx +: XLEN];
            end
`endif
        end
    end

    assign req_ready   = ~r_full | w_grant;
    assign w_acc       = req_valid & req_ready;
    assign pending_cnt = r_pending;

    // rd==0 results and results written straight through the bypass are never stored.
    always_comb begin
        w_load     = '0;
        w_full_nxt = '0;
        for (int i = 0; i < N_FU; i++) begin
            w_load[i]     = w_acc[i] & w_req_nz[i] & ~(w_grant[i] & ~r_full[i]);
            w_full_nxt[i] = w_load[i] | (r_full[i] & ~w_grant[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= '0;
            r_pending <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_full    <= w_full_nxt;
            r_pending <= popcount(w_full_nxt);
            if (w_found)
                r_rr_ptr <= (w_gidx == PTR_W'(N_FU-1)) ? '0 : w_gidx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (w_load[i]) begin
                r_rd_q[i]   <= req_rd[5*i +: 5];
                r_data_q[i] <= req_data[XLEN*i +: XLEN];
            end
        end
    end

endmodule
